// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: iterative AES SubBytes / InvSubBytes unit.
// A 128-bit block is captured into a working register and substituted in
// place, LANES bytes per cycle, using the mode latched with the block.
// Valid/ready handshakes on both sides let the round controller stall it.
module sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    // Number of RUN cycles per block and the chunk counter width.
    localparam int NCHUNK = 16 / LANES;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    // Tables indexed by byte value; entry v sits at bits [2047-8v -: 8] so
    // the literal reads left to right in FIPS-197 row order.
    localparam logic [2047:0] C_SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] C_SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [127:0]       r_work;
    logic               r_mode;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_last;
    logic [127:0]       w_work_sub;
    logic [7:0]         w_byte;
    int                 w_base;

    function automatic logic [7:0] f_sbox_fwd(input logic [7:0] b);
        return C_SBOX_FWD[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] f_sbox_inv(input logic [7:0] b);
        return C_SBOX_INV[2047 - 8 * int'(b) -: 8];
    endfunction

    // The chunk addressed by r_cnt is the final one of the block.
    assign w_last = (r_cnt == CNT_W'(NCHUNK - 1));

    // Substitute the current chunk of LANES bytes; all other bytes pass through.
    always_comb begin
        w_work_sub = r_work;
        w_byte     = 8'h00;
        w_base     = int'(r_cnt) * LANES;
        for (int l = 0; l < LANES; l++) begin
            w_byte = r_work[127 - 8 * (w_base + l) -: 8];
            w_work_sub[127 - 8 * (w_base + l) -: 8] =
                r_mode ? f_sbox_inv(w_byte) : f_sbox_fwd(w_byte);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Working register, latched mode and chunk counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_work <= '0;
            r_mode <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work <= in_data;
                        r_mode <= in_mode;
                        r_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    r_work <= w_work_sub;
                    if (!w_last) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_work <= r_work;
                end
            endcase
        end
    end

    // The result is read straight from the working register.
    assign out_data = r_work;

endmodule

// File: doc/sub_bytes_seq.md
# sub_bytes_seq

Sequential, parametrised AES byte-substitution unit. It applies either the forward SubBytes S-box or the inverse (InvSubBytes) S-box to a 128-bit state, LANES bytes per cycle, and signals per-block selection of mode. It sits between the round-key/ShiftRows stages of the iterative AES datapath and trades area (LANES S-box copies per direction) against latency. Valid/ready handshakes on both sides let it stall against the round controller.

## Interface
- LANES, default 4: S-box copies per direction, i.e. bytes substituted per cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input block present.
- in_ready  out  1  unit can accept a block.
- in_mode  in  1  0 = forward S-box, 1 = inverse S-box; sampled with the block.
- in_data  in  128  state; byte k occupies bits [127-8k : 120-8k], so byte 0 is most significant.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  128  substituted state, same byte order.
- busy  out  1  high in RUN or DONE.

## Operation
- Each byte is substituted independently with its own value. Output byte k = S(in byte k) or S⁻¹(in byte k); no byte is ever taken from another position.
- Both tables are the FIPS-197 tables, held as 2048-bit constants indexed by byte value.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, load in_data into the working register, latch in_mode, clear the chunk counter, go to RUN.
  - RUN: each cycle, replace bytes cnt*LANES .. cnt*LANES+LANES-1 of the working register in place, using the latched mode, then cnt++. When cnt reaches 16/LANES-1 that cycle is the last; go to DONE.
  - DONE: out_valid=1 and out_data = working register, held stable until out_ready. On out_valid&&out_ready go to IDLE.
- in_ready is high only in IDLE. in_valid in RUN or DONE is ignored and not captured.
- in_mode and in_data changes after acceptance have no effect on the block in flight.
- out_data is driven from the working register. In IDLE it holds the last result; this value is don't-care to the consumer.
- Counter width is clog2(16/LANES), minimum 1 bit. The counter does not wrap within a block because the exit condition is checked on the last chunk.
- LANES=16 gives exactly one RUN cycle.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, busy=0, out_data=0, counter=0, latched mode=0.
- Reset asserted mid-operation: the unit returns to IDLE immediately, the block is discarded, and no out_valid is produced after release.
- Latency: acceptance at edge E0, then out_valid rises after edge E0+16/LANES. For LANES=4, out_valid is visible 4 cycles after acceptance.
- With out_ready held high, DONE lasts 1 cycle and in_ready returns the cycle after.
- Minimum spacing between accepted blocks is 16/LANES+2 cycles.
- out_ready low in DONE: the unit stalls indefinitely with out_data stable and in_ready=0.
- out_ready high in IDLE/RUN has no effect.
- Both handshakes use transfer-on-edge semantics: a transfer happens on an edge where valid and ready are both high.

## Test plan
- Forward mode, LANES=4: in_data=00112233445566778899aabbccddeeff, out_ready=1 -> out_valid exactly 4 cycles after acceptance with out_data=638293c31bfc33f5c4eeac ea4bc12816 (i.e. 638293c31bfc33f5c4eeacea4bc12816).
- Inverse mode, LANES=4: in_data=638293c31bfc33f5c4eeacea4bc12816 -> out_data=00112233445566778899aabbccddeeff. Separately, all-zero input -> 52 in every byte.
- Parameter sweep LANES=1,2,8,16 with the forward vector above -> identical out_data; out_valid latency 16, 8, 2 and 1 cycles respectively.
- Backpressure: hold out_ready=0 for 10 cycles in DONE, and toggle in_valid/in_data/in_mode meanwhile -> out_data unchanged, in_ready=0, and no extra block accepted. Release out_ready -> one transfer, then in_ready=1 the next cycle.
- Mode latching: accept a block with in_mode=1, then drive in_mode=0 during RUN -> result is the inverse substitution (e.g. byte 63 -> 00, ed -> 53).
- Reset mid-RUN: assert rst_n=0 at cycle 2 of RUN -> out_valid=0, in_ready=1 and busy=0 immediately. After release, a fresh block completes with correct data and no stale out_valid.
